balik_besleyici: RTL and testbench
==================================

Name: balik_besleyici

Overview:
Fish-supply transmitter that drives the 3-bit per-cycle catch input of the penguin consumer block. It holds a finite fish stock and generates per-cycle catch amounts from an LFSR. It keeps a cycle-exact mirror of the consumer's stomach and digestion model so it stops on the same clock edge the consumer reports full. It also stops on explicit consumer feedback or when the stock runs out.

Parameters:
STOK, 8'd60, initial fish stock loaded at reset.
LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.
MIDE_LIMIT, 5'd25, consumer fullness threshold (compare is >=).
SINDIRIM, 3'd3, amount digested on a digestion cycle.
SINDIRIM_PERIYOT, 2'd3, digestion occurs when feed count mod period == period-1.

Ports:
saat  input  1  clock, rising edge.
reset  input  1  reset, synchronous, active-high.
basla  input  1  start request; sampled only in IDLE.
penguen_bitti  input  1  consumer full flag (consumer's registered done output).
avlanan_balik  output  3  catch amount presented this cycle; 0 when gecerli=0.
gecerli  output  1  high while in FEED and amount is being presented.
toplam_balik  output  8  total fish accepted by consumer.
kalan_stok  output  8  remaining stock.
durum  output  2  state: 0 IDLE, 1 FEED, 2 DONE_FULL, 3 DONE_STOCK.

Behaviour:
- Reset: durum=IDLE, kalan_stok=STOK, toplam_balik=0, lfsr=LFSR_SEED, mirror mide=0, feed counter=0. gecerli=0 and avlanan_balik=0. Reset mid-FEED aborts immediately; the next cycle is IDLE.
- IDLE: basla=1 moves to FEED on the next edge. No other exit.
- FEED amount A = min(lfsr[2:0], kalan_stok). It is combinational from registers only, with no path from inputs. avlanan_balik=A and gecerli=1.
- FEED priority at each edge, highest first:
  (1) penguen_bitti=1 -> DONE_FULL; no stock or total update.
  (2) kalan_stok==0 -> DONE_STOCK.
  (3) mirror predicts full (mide+A >= MIDE_LIMIT, 5-bit+3-bit sum evaluated at 6 bits) -> DONE_FULL. A is rejected: stock, total and LFSR are unchanged, matching the consumer discarding that catch.
  (4) Otherwise accept:
      - kalan_stok -= A and toplam_balik += A.
      - lfsr advances: shift left, new bit0 = b7^b5^b4^b3.
      - Feed counter (7-bit) increments.
      - mide updates with 5-bit modulo arithmetic identical to the consumer: if counter mod SINDIRIM_PERIYOT == SINDIRIM_PERIYOT-1 then mide = mide+A-SINDIRIM, else mide = mide+A. Wrap-around is intentional so the mirror stays bit-exact.
- A=0 cycles are valid accepts: the counter advances, and digestion applies on digestion cycles.
- DONE_FULL and DONE_STOCK are terminal until reset. basla is ignored there. Outputs hold their final values; gecerli=0.
- toplam_balik + kalan_stok == STOK in every state.

Optional Feature:
Macro BESLEYICI_AYNA_EN.
- Defined: stomach mirror and priority (3) are present. DONE_FULL is entered on the same edge the consumer sets its done flag.
- Undefined: no mirror logic. Fullness is detected only via penguen_bitti, so exit is one cycle later. The rejected amount on the consumer's terminating edge is still deducted, so totals may exceed the consumer's accepted sum by that amount.

Test Plan:
- STOK=0, reset, pulse basla -> FEED for 1 cycle with avlanan_balik=0, then durum=3, toplam_balik=0.
- STOK=5, consumer stub never full -> durum=3, toplam_balik=5, kalan_stok=0; last amount clipped to the remaining stock.
- STOK=255, real consumer connected, BESLEYICI_AYNA_EN defined -> durum becomes 2 on the same edge consumer done rises. toplam_balik equals the sum of amounts accepted by the consumer.
- Same as the previous scenario with the macro undefined -> durum=2 exactly one cycle after consumer done rises.
- In FEED, force penguen_bitti=1 with kalan_stok=0 simultaneously -> durum=2 (full wins); totals unchanged.
- Reset asserted mid-FEED after 4 accepts -> next cycle durum=0, kalan_stok=STOK, toplam_balik=0; re-run reproduces the same amount sequence from LFSR_SEED (first amount 3'd5).

Source files
------------

// File: rtl/balik_besleyici_if.sv
// Catch/feedback bundle between the fish-supply transmitter and the penguin consumer.
interface balik_besleyici_if;
  logic       basla;
  logic       penguen_bitti;
  logic [2:0] avlanan_balik;
  logic       gecerli;
  logic [7:0] toplam_balik;
  logic [7:0] kalan_stok;
  logic [1:0] durum;

  modport master (
    input  basla,
    input  penguen_bitti,
    output avlanan_balik,
    output gecerli,
    output toplam_balik,
    output kalan_stok,
    output durum
  );

  modport slave (
    output basla,
    output penguen_bitti,
    input  avlanan_balik,
    input  gecerli,
    input  toplam_balik,
    input  kalan_stok,
    input  durum
  );
endinterface

// File: rtl/balik_besleyici.sv
// Fish-supply transmitter: LFSR-driven catch amounts from a finite stock.
// Define BESLEYICI_AYNA_EN to add the consumer stomach mirror for same-edge full detection.
module balik_besleyici #(
  parameter logic [7:0] STOK             = 8'd60,
  parameter logic [7:0] LFSR_SEED        = 8'hA5,
  parameter logic [4:0] MIDE_LIMIT       = 5'd25,
  parameter logic [2:0] SINDIRIM         = 3'd3,
  parameter logic [1:0] SINDIRIM_PERIYOT = 2'd3
) (
  input logic               saat,
  input logic               reset,
  balik_besleyici_if.master besleme
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FEED       = 2'd1,
    DONE_FULL  = 2'd2,
    DONE_STOCK = 2'd3
  } durum_t;

  durum_t     durum_q, durum_d;
  logic [7:0] kalan_q, kalan_d;
  logic [7:0] toplam_q, toplam_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] miktar;
  logic       tam_tahmin;
  logic       kabul;

  assign miktar = ({5'd0, lfsr_q[2:0]} <= kalan_q) ? lfsr_q[2:0] : kalan_q[2:0];

  assign kabul = (durum_q == FEED) && !besleme.penguen_bitti &&
                 (kalan_q != 8'd0) && !tam_tahmin;

`ifdef BESLEYICI_AYNA_EN
  logic [4:0] mide_q, mide_d;
  logic [6:0] sayac_q, sayac_d;
  logic       sindirim_dongusu;

  // 6-bit sum so the threshold compare never wraps; stomach itself wraps at 5 bits like the consumer.
  assign tam_tahmin = ({1'b0, mide_q} + {3'b000, miktar}) >= {1'b0, MIDE_LIMIT};
  assign sindirim_dongusu = (sayac_q % {5'd0, SINDIRIM_PERIYOT}) ==
                            ({5'd0, SINDIRIM_PERIYOT} - 7'd1);

  always_comb begin
    mide_d  = mide_q;
    sayac_d = sayac_q;
    if (kabul) begin
      sayac_d = sayac_q + 7'd1;
      if (sindirim_dongusu)
        mide_d = mide_q + {2'b00, miktar} - {2'b00, SINDIRIM};
      else
        mide_d = mide_q + {2'b00, miktar};
    end
  end

  always_ff @(posedge saat) begin
    if (reset) begin
      mide_q  <= '0;
      sayac_q <= '0;
    end else begin
      mide_q  <= mide_d;
      sayac_q <= sayac_d;
    end
  end
`else
  assign tam_tahmin = 1'b0;
`endif

  always_ff @(posedge saat) begin
    if (reset) begin
      durum_q  <= IDLE;
      kalan_q  <= STOK;
      toplam_q <= '0;
      lfsr_q   <= LFSR_SEED;
    end else begin
      durum_q  <= durum_d;
      kalan_q  <= kalan_d;
      toplam_q <= toplam_d;
      lfsr_q   <= lfsr_d;
    end
  end

  always_comb begin
    durum_d  = durum_q;
    kalan_d  = kalan_q;
    toplam_d = toplam_q;
    lfsr_d   = lfsr_q;
    unique case (durum_q)
      IDLE: if (besleme.basla) durum_d = FEED;
      FEED: begin
        if (besleme.penguen_bitti) durum_d = DONE_FULL;
        else if (kalan_q == 8'd0)  durum_d = DONE_STOCK;
        else if (tam_tahmin)       durum_d = DONE_FULL;
        if (kabul) begin
          kalan_d  = kalan_q - {5'd0, miktar};
          toplam_d = toplam_q + {5'd0, miktar};
          lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    besleme.gecerli       = (durum_q == FEED);
    besleme.avlanan_balik = (durum_q == FEED) ? miktar : '0;
    besleme.toplam_balik  = toplam_q;
    besleme.kalan_stok    = kalan_q;
    besleme.durum         = durum_q;
  end

endmodule

// File: tb/tb_balik_besleyici.sv
// Directed bench: three transmitter instances (stock 255 with a consumer model, stock 0, stock 5).
module tb_balik_besleyici;

  logic saat = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 saat = ~saat;

  balik_besleyici_if ana_if ();
  balik_besleyici_if sifir_if ();
  balik_besleyici_if bes_if ();

  balik_besleyici #(.STOK(8'd255)) u_ana   (.saat(saat), .reset(reset), .besleme(ana_if.master));
  balik_besleyici #(.STOK(8'd0))   u_sifir (.saat(saat), .reset(reset), .besleme(sifir_if.master));
  balik_besleyici #(.STOK(8'd5))   u_bes   (.saat(saat), .reset(reset), .besleme(bes_if.master));

`ifdef BESLEYICI_AYNA_EN
  localparam int BEKLENEN_TAM_KENAR = 9;
  localparam int BEKLENEN_TOPLAM    = 29;
`else
  localparam int BEKLENEN_TAM_KENAR = 10;
  localparam int BEKLENEN_TOPLAM    = 35;
`endif

  // Penguin consumer: limit 25, digest 3 every third accepted catch, discards the overflowing catch.
  logic [4:0] mide_c;
  logic [6:0] sayac_c;
  logic       bitti_c;
  logic [7:0] toplam_c;

  always @(posedge saat) begin
    if (reset) begin
      mide_c   <= '0;
      sayac_c  <= '0;
      bitti_c  <= 1'b0;
      toplam_c <= '0;
    end else if (ana_if.gecerli && !bitti_c) begin
      if (({1'b0, mide_c} + {3'b000, ana_if.avlanan_balik}) >= 6'd25) begin
        bitti_c <= 1'b1;
      end else begin
        if (sayac_c % 7'd3 == 7'd2) mide_c <= mide_c + {2'b00, ana_if.avlanan_balik} - 5'd3;
        else                        mide_c <= mide_c + {2'b00, ana_if.avlanan_balik};
        sayac_c  <= sayac_c + 7'd1;
        toplam_c <= toplam_c + {5'd0, ana_if.avlanan_balik};
      end
    end
  end

  assign ana_if.penguen_bitti   = bitti_c;
  assign sifir_if.penguen_bitti = 1'b0;

  task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
    checks++;
    if (gozlenen !== beklenen) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", etiket, gozlenen, beklenen);
    end
  endtask

  task automatic tick();
    @(posedge saat);
    #1;
  endtask

  int tam_kenar;
  int bitti_kenar;
  int dizi [4] = '{5, 2, 5, 2};

  initial begin
    reset = 1'b1;
    ana_if.basla   = 1'b0;
    sifir_if.basla = 1'b0;
    bes_if.basla   = 1'b0;
    bes_if.penguen_bitti = 1'b0;
    repeat (2) tick();

    kontrol("reset_durum",  int'(ana_if.durum), 0);
    kontrol("reset_kalan",  int'(ana_if.kalan_stok), 255);
    kontrol("reset_toplam", int'(ana_if.toplam_balik), 0);
    kontrol("reset_gecerli", int'(ana_if.gecerli), 0);
    kontrol("reset_avlanan", int'(ana_if.avlanan_balik), 0);
    reset = 1'b0;

    // Zero stock: one FEED cycle presenting 0, then DONE_STOCK.
    sifir_if.basla = 1'b1; tick(); sifir_if.basla = 1'b0;
    kontrol("s0_durum_feed", int'(sifir_if.durum), 1);
    kontrol("s0_gecerli",    int'(sifir_if.gecerli), 1);
    kontrol("s0_avlanan",    int'(sifir_if.avlanan_balik), 0);
    tick();
    kontrol("s0_durum_son",  int'(sifir_if.durum), 3);
    kontrol("s0_toplam",     int'(sifir_if.toplam_balik), 0);
    kontrol("s0_gecerli_son", int'(sifir_if.gecerli), 0);
    sifir_if.basla = 1'b1; tick(); sifir_if.basla = 1'b0;
    kontrol("s0_basla_yok", int'(sifir_if.durum), 3);

    // Stock 5: amount 5, then clipped to 0, then DONE_STOCK.
    bes_if.basla = 1'b1; tick(); bes_if.basla = 1'b0;
    kontrol("s5_ilk", int'(bes_if.avlanan_balik), 5);
    tick();
    kontrol("s5_kirpik", int'(bes_if.avlanan_balik), 0);
    kontrol("s5_kalan0", int'(bes_if.kalan_stok), 0);
    tick();
    kontrol("s5_durum",  int'(bes_if.durum), 3);
    kontrol("s5_toplam", int'(bes_if.toplam_balik), 5);
    kontrol("s5_kalan",  int'(bes_if.kalan_stok), 0);

    // Full flag and empty stock together: full wins.
    reset = 1'b1; tick(); reset = 1'b0;
    kontrol("s5_reset_kalan", int'(bes_if.kalan_stok), 5);
    bes_if.basla = 1'b1; tick(); bes_if.basla = 1'b0;
    tick();
    bes_if.penguen_bitti = 1'b1; tick(); bes_if.penguen_bitti = 1'b0;
    kontrol("oncelik_durum",  int'(bes_if.durum), 2);
    kontrol("oncelik_toplam", int'(bes_if.toplam_balik), 5);
    kontrol("oncelik_kalan",  int'(bes_if.kalan_stok), 0);

    // Stock 255 against the consumer model.
    tam_kenar = 0;
    bitti_kenar = 0;
    ana_if.basla = 1'b1; tick(); ana_if.basla = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bitti_c && bitti_kenar == 0) bitti_kenar = n;
      if (ana_if.durum == 2'd2 && tam_kenar == 0) tam_kenar = n;
      if (ana_if.durum != 2'd1) break;
    end
    kontrol("tuk_bitti_kenar", bitti_kenar, 9);
    kontrol("tuk_tam_kenar",   tam_kenar, BEKLENEN_TAM_KENAR);
    kontrol("tuk_tuketici_top", int'(toplam_c), 29);
    kontrol("tuk_toplam",      int'(ana_if.toplam_balik), BEKLENEN_TOPLAM);
    kontrol("tuk_kalan",       int'(ana_if.kalan_stok), 255 - BEKLENEN_TOPLAM);

    // Reset mid-FEED after four accepts, then replay from the seed.
    reset = 1'b1; tick(); reset = 1'b0;
    ana_if.basla = 1'b1; tick(); ana_if.basla = 1'b0;
    for (int i = 0; i < 4; i++) begin
      kontrol($sformatf("dizi_%0d", i), int'(ana_if.avlanan_balik), dizi[i]);
      tick();
    end
    kontrol("ara_toplam", int'(ana_if.toplam_balik), 14);
    kontrol("ara_kalan",  int'(ana_if.kalan_stok), 241);
    reset = 1'b1; tick(); reset = 1'b0;
    kontrol("abort_durum",  int'(ana_if.durum), 0);
    kontrol("abort_kalan",  int'(ana_if.kalan_stok), 255);
    kontrol("abort_toplam", int'(ana_if.toplam_balik), 0);
    ana_if.basla = 1'b1; tick(); ana_if.basla = 1'b0;
    kontrol("tekrar_ilk", int'(ana_if.avlanan_balik), 5);
    tick();
    kontrol("tekrar_ikinci", int'(ana_if.avlanan_balik), 2);
    kontrol("tekrar_toplam", int'(ana_if.toplam_balik), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
